muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit. Sits between regfile read ports and regfile write port.
- Consumes read_data1/read_data2 as operands. Produces a result plus destination register index for the writeback mux that drives regfile wr_addr/wr_data/wr_en.
- The core stalls on ready_o/valid_o. One operation in flight at a time.

Parameters:
- DataWidth, 32, operand/result width.
- AddressWidth, 5, destination register index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  request; accepted when start_i && ready_o && !flush_i.
- op_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a_i  in  DataWidth  rs1 value.
- operand_b_i  in  DataWidth  rs2 value.
- rd_i  in  AddressWidth  destination register index.
- flush_i  in  1  abort the in-flight operation and drop any pending result.
- ack_i  in  1  writeback consumed the result.
- ready_o  out  1  unit idle; can accept a request.
- valid_o  out  1  result_o/rd_o hold a completed result.
- result_o  out  DataWidth  operation result.
- rd_o  out  AddressWidth  destination index of the result.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state IDLE, ready_o=1, valid_o=0, result_o=0, rd_o=0, counter=0. Reset mid-operation discards all work.
- States: IDLE, BUSY, FIX, DONE.
  - ready_o = (state==IDLE).
  - valid_o = (state==DONE).
- IDLE:
  - On acceptance, latch op, operand magnitudes, sign flags and rd; clear counter.
  - Next state is BUSY, or DONE for the fast path.
- Fast path (division ops only): IDLE→DONE on the acceptance edge. valid_o is high 1 cycle after acceptance.
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return operand_a.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- BUSY:
  - Exactly DataWidth cycles, counter 0..DataWidth-1, one bit per cycle.
  - Multiply: shift-add on magnitudes, 2*DataWidth-bit product.
  - Divide: restoring on magnitudes, producing quotient and remainder.
  - At counter==DataWidth-1, next state is FIX.
- Signedness of magnitudes:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- FIX (one cycle): apply sign correction, select the result, then go to DONE.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - MUL returns the low half of the product; MULH/MULHSU/MULHU return the high half.
- Normal-path latency: valid_o is high DataWidth+2 cycles after acceptance (34 for the default).
- DONE:
  - result_o and rd_o are held stable until ack_i.
  - On ack_i, go to IDLE; ready_o is high the next cycle.
  - No same-cycle accept in DONE.
- rd_o==0 results are still presented; the regfile suppresses x0 writes.
- flush_i in any state: next state IDLE, valid_o=0. result_o/rd_o keep their last values (don't-care).
- Simultaneous flush_i and start_i in IDLE: flush wins, the request is not accepted.
- start_i while not ready_o: ignored. Inputs are not sampled outside the acceptance cycle.
- ack_i outside DONE: ignored.
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, rd=5.
  - Required: valid_o rises exactly 34 cycles after acceptance, result 0xFFFFFFEB, rd_o=5.
  - Then ack → ready_o=1 the next cycle.
- a=b=0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
  - MUL → 0x00000001.
- Division results:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU → 2.
  - REM 7/0xFFFFFFFE → 1.
- Fast path, each with valid_o high 1 cycle after acceptance:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure: hold ack_i=0 for 10 cycles in DONE with start_i pulsing.
  - Required: result_o/rd_o stable, ready_o=0, no new acceptance.
  - After ack, a new op is accepted normally.
- Abort cases:
  - flush_i in BUSY cycle 10 → valid_o never asserts; ready_o=1 the next cycle.
  - rst_i at BUSY cycle 20 → same outcome, plus all outputs at their reset values.
  - flush_i with start_i in IDLE → no acceptance.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the RV32M multiply/divide unit.
// master: core side (issues requests, acknowledges results).
// slave : muldiv_unit side.
//   start_i, op_i, operand_a_i, operand_b_i, rd_i : request and operands
//   flush_i                                       : abort in-flight work
//   ack_i                                         : writeback consumed the result
//   ready_o, valid_o, result_o, rd_o              : status and completed result
interface muldiv_unit_if #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 5
);
    logic                    start_i;
    logic [2:0]              op_i;
    logic [DataWidth-1:0]    operand_a_i;
    logic [DataWidth-1:0]    operand_b_i;
    logic [AddressWidth-1:0] rd_i;
    logic                    flush_i;
    logic                    ack_i;
    logic                    ready_o;
    logic                    valid_o;
    logic [DataWidth-1:0]    result_o;
    logic [AddressWidth-1:0] rd_o;

    modport master (
        output start_i, op_i, operand_a_i, operand_b_i, rd_i, flush_i, ack_i,
        input  ready_o, valid_o, result_o, rd_o
    );

    modport slave (
        input  start_i, op_i, operand_a_i, operand_b_i, rd_i, flush_i, ack_i,
        output ready_o, valid_o, result_o, rd_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One operation in flight; DataWidth
// iterations of shift-add (multiply) or restoring division on operand
// magnitudes, then one cycle of sign correction.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : muldiv_unit_if slave (request, flush, ack, ready/valid, result, rd)
module muldiv_unit #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    muldiv_unit_if.slave        bus
);
    localparam int unsigned CntWidth = $clog2(DataWidth);
    localparam logic [CntWidth-1:0]  CntLast = CntWidth'(DataWidth - 1);
    localparam logic [DataWidth-1:0] MinVal  = {1'b1, {(DataWidth-1){1'b0}}};

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;
    localparam logic [2:0] OpRemu   = 3'b111;

    typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic [AddressWidth-1:0] rd_q, rd_d;
    logic [DataWidth-1:0]    result_q, result_d;
    logic [CntWidth-1:0]     counter_q, counter_d;
    // Multiplicand (multiply) or divisor (divide) magnitude.
    logic [DataWidth-1:0]    mag_q, mag_d;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*DataWidth-1:0]  work_q, work_d;
    logic                    neg_res_q, neg_res_d;
    logic                    neg_rem_q, neg_rem_d;

    logic                    accept;
    logic                    a_signed, b_signed, a_neg, b_neg;
    logic [DataWidth-1:0]    a_mag, b_mag;
    logic                    div_zero, div_ovf;
    logic [DataWidth-1:0]    fast_res;
    logic [DataWidth:0]      mul_sum;
    logic [DataWidth:0]      div_shift, div_diff;
    logic [2*DataWidth-1:0]  prod_fix;
    logic [DataWidth-1:0]    quot, rem;

    assign bus.ready_o  = (state_q == StIdle);
    assign bus.valid_o  = (state_q == StDone);
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_q;

    // Flush wins over a simultaneous request.
    assign accept = bus.start_i && (state_q == StIdle) && !bus.flush_i;

    assign a_signed = !(bus.op_i == OpMulhu || bus.op_i == OpDivu || bus.op_i == OpRemu);
    assign b_signed = (bus.op_i == OpMul) || (bus.op_i == OpMulh) ||
                      (bus.op_i == OpDiv) || (bus.op_i == OpRem);
    assign a_neg    = a_signed && bus.operand_a_i[DataWidth-1];
    assign b_neg    = b_signed && bus.operand_b_i[DataWidth-1];
    assign a_mag    = a_neg ? -bus.operand_a_i : bus.operand_a_i;
    assign b_mag    = b_neg ? -bus.operand_b_i : bus.operand_b_i;

    // Division corner cases resolved without iterating.
    assign div_zero = bus.op_i[2] && (bus.operand_b_i == '0);
    assign div_ovf  = bus.op_i[2] && !bus.op_i[0] && (bus.operand_a_i == MinVal) &&
                      (bus.operand_b_i == '1);
    always_comb begin
        if (div_zero) begin
            fast_res = bus.op_i[1] ? bus.operand_a_i : '1;
        end else begin
            fast_res = bus.op_i[1] ? '0 : MinVal;
        end
    end

    // One iteration of each algorithm.
    assign mul_sum   = {1'b0, work_q[2*DataWidth-1:DataWidth]} +
                       {1'b0, (work_q[0] ? mag_q : {DataWidth{1'b0}})};
    assign div_shift = {work_q[2*DataWidth-1:DataWidth], work_q[DataWidth-1]};
    assign div_diff  = div_shift - {1'b0, mag_q};

    assign prod_fix  = neg_res_q ? -work_q : work_q;
    assign quot      = work_q[DataWidth-1:0];
    assign rem       = work_q[2*DataWidth-1:DataWidth];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        result_d  = result_q;
        counter_d = counter_q;
        mag_d     = mag_q;
        work_d    = work_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = bus.op_i;
                    rd_d      = bus.rd_i;
                    counter_d = '0;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (bus.op_i[2]) begin
                        mag_d  = b_mag;
                        work_d = {{DataWidth{1'b0}}, a_mag};
                    end else begin
                        mag_d  = a_mag;
                        work_d = {{DataWidth{1'b0}}, b_mag};
                    end
                    if (div_zero || div_ovf) begin
                        result_d = fast_res;
                        state_d  = StDone;
                    end else begin
                        state_d  = StBusy;
                    end
                end
            end
            StBusy: begin
                counter_d = counter_q + 1'b1;
                if (op_q[2]) begin
                    // Restoring step: keep the difference only if it did not borrow.
                    if (!div_diff[DataWidth]) begin
                        work_d = {div_diff[DataWidth-1:0], work_q[DataWidth-2:0], 1'b1};
                    end else begin
                        work_d = {div_shift[DataWidth-1:0], work_q[DataWidth-2:0], 1'b0};
                    end
                end else begin
                    work_d = {mul_sum, work_q[DataWidth-1:1]};
                end
                if (counter_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (op_q[2]) begin
                    if (op_q[1]) begin
                        result_d = neg_rem_q ? -rem : rem;
                    end else begin
                        result_d = neg_res_q ? -quot : quot;
                    end
                end else if (op_q[1:0] == 2'b00) begin
                    result_d = prod_fix[DataWidth-1:0];
                end else begin
                    result_d = prod_fix[2*DataWidth-1:DataWidth];
                end
                state_d = StDone;
            end
            StDone: begin
                if (bus.ack_i) begin
                    state_d = StIdle;
                end
            end
        endcase

        if (bus.flush_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            op_q      <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            counter_q <= '0;
            mag_q     <= '0;
            work_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            counter_q <= counter_d;
            mag_q     <= mag_d;
            work_q    <= work_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    muldiv_unit_if #(.DataWidth(32), .AddressWidth(5)) bus ();

    muldiv_unit #(.DataWidth(32), .AddressWidth(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, su, p;
        logic signed [31:0] qa, qb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        su = {32'b0, b};
        qa = a;
        qb = b;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * su; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return qa / qb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return qa % qb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    // Issue one op from IDLE, wait (bounded) for valid, acknowledge it.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res,
                          output logic [4:0] rdo, output int lat);
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.op_i        = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        bus.rd_i        = rd;
        @(negedge clk);
        bus.start_i = 1'b0;
        lat = 1;
        while (!bus.valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = bus.result_o;
        rdo = bus.rd_o;
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        check("ready_after_ack", {63'b0, bus.ready_o}, 64'd1);
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res, ra, rb;
        logic [4:0]  rdo, rrd;
        logic [2:0]  rop;
        int          lat;
        logic        seen;

        n_checks = 0;
        n_fail   = 0;
        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.op_i        = '0;
        bus.operand_a_i = '0;
        bus.operand_b_i = '0;
        bus.rd_i        = '0;
        bus.flush_i     = 1'b0;
        bus.ack_i       = 1'b0;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 34};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 34};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'h0000_0001, 34};
        vecs[5]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFD, 34};
        vecs[6]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFF, 34};
        vecs[7]  = '{3'd5, 32'd100,        32'd7,         5'd8,  32'd14,        34};
        vecs[8]  = '{3'd7, 32'd100,        32'd7,         5'd9,  32'd2,         34};
        vecs[9]  = '{3'd6, 32'd7,          32'hFFFF_FFFE, 5'd10, 32'd1,         34};
        vecs[10] = '{3'd4, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 1};
        vecs[11] = '{3'd7, 32'd5,          32'd0,         5'd12, 32'd5,         1};
        vecs[12] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1};
        vecs[13] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'd0,         1};
        vecs[14] = '{3'd0, 32'd12345,      32'd0,         5'd0,  32'd0,         34};
        vecs[15] = '{3'd5, 32'hFFFF_FFFF,  32'd1,         5'd31, 32'hFFFF_FFFF, 34};

        repeat (3) @(negedge clk);
        check("reset_ready",  {63'b0, bus.ready_o}, 64'd1);
        check("reset_valid",  {63'b0, bus.valid_o}, 64'd0);
        check("reset_result", {32'b0, bus.result_o}, 64'd0);
        check("reset_rd",     {59'b0, bus.rd_o},    64'd0);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, res, rdo, lat);
            check($sformatf("vec%0d_result", i), {32'b0, res}, {32'b0, vecs[i].exp});
            check($sformatf("vec%0d_rd", i), {59'b0, rdo}, {59'b0, vecs[i].rd});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick($urandom_range(0, 5));
            rb  = pick($urandom_range(0, 5));
            rrd = 5'($urandom);
            run_op(rop, ra, rb, rrd, res, rdo, lat);
            check($sformatf("rand%0d_op%0d_result", i, rop), {32'b0, res},
                  {32'b0, ref_model(rop, ra, rb)});
            check($sformatf("rand%0d_rd", i), {59'b0, rdo}, {59'b0, rrd});
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(ref_latency(rop, ra, rb)));
        end

        // Backpressure: result held in DONE while start_i pulses.
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'd0; bus.operand_a_i = 32'd3;
        bus.operand_b_i = 32'd5; bus.rd_i = 5'd9;
        @(negedge clk);
        bus.start_i = 1'b0;
        lat = 1;
        while (!bus.valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 64'(lat), 64'd34);
        for (int i = 0; i < 10; i++) begin
            bus.start_i     = i[0];
            bus.op_i        = 3'd5;
            bus.operand_a_i = $urandom;
            bus.operand_b_i = 32'd0;
            bus.rd_i        = 5'd20;
            @(negedge clk);
            check("bp_result", {32'b0, bus.result_o}, 64'd15);
            check("bp_rd",     {59'b0, bus.rd_o},     64'd9);
            check("bp_ready",  {63'b0, bus.ready_o},  64'd0);
            check("bp_valid",  {63'b0, bus.valid_o},  64'd1);
        end
        bus.start_i = 1'b0;
        bus.ack_i   = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        check("bp_ready_after_ack", {63'b0, bus.ready_o}, 64'd1);
        run_op(3'd5, 32'd100, 32'd7, 5'd17, res, rdo, lat);
        check("bp_next_result",  {32'b0, res}, 64'd14);
        check("bp_next_rd",      {59'b0, rdo}, 64'd17);
        check("bp_next_latency", 64'(lat),     64'd34);

        // Flush in BUSY cycle 10.
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'd0; bus.operand_a_i = 32'd9;
        bus.operand_b_i = 32'd9; bus.rd_i = 5'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_ready_before", {63'b0, bus.ready_o}, 64'd0);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_ready", {63'b0, bus.ready_o}, 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_o) seen = 1'b1;
        end
        check("flush_no_valid", {63'b0, seen}, 64'd0);

        // Reset in BUSY cycle 20 (result_o is nonzero from the last op).
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'd4; bus.operand_a_i = 32'd1000;
        bus.operand_b_i = 32'd3; bus.rd_i = 5'd12;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready",  {63'b0, bus.ready_o}, 64'd1);
        check("rst_valid",  {63'b0, bus.valid_o}, 64'd0);
        check("rst_result", {32'b0, bus.result_o}, 64'd0);
        check("rst_rd",     {59'b0, bus.rd_o},    64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_o) seen = 1'b1;
        end
        check("rst_no_valid", {63'b0, seen}, 64'd0);

        // Flush together with start in IDLE: request dropped (fast-path op).
        @(negedge clk);
        bus.start_i = 1'b1; bus.flush_i = 1'b1; bus.op_i = 3'd4;
        bus.operand_a_i = 32'd5; bus.operand_b_i = 32'd0; bus.rd_i = 5'd7;
        @(negedge clk);
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        check("flush_start_ready", {63'b0, bus.ready_o}, 64'd1);
        check("flush_start_valid", {63'b0, bus.valid_o}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_o) seen = 1'b1;
        end
        check("flush_start_no_valid", {63'b0, seen}, 64'd0);

        // Still operational afterwards.
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, res, rdo, lat);
        check("final_result", {32'b0, res}, 64'hFFFF_FFFF);
        check("final_rd",     {59'b0, rdo}, 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
